// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: valid/ready request channel plus
// a single-cycle response pulse. The fetch unit is the master.
interface fetch_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic                     imem_resp_valid;
  logic [DATA_WIDTH-1:0]    imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// feeds decode through a registered output with a one-entry skid buffer.
module fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fetch_unit_if.master             imem,
  input  logic                     stall_f,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic                     instr_valid_f
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]               state_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] req_pc_q;
  logic [DATA_WIDTH-1:0]    skid_data_q;
  logic                     skid_vld_q;
  logic                     discard_q;
  logic                     req_hs;
  logic                     resp_take;

  function automatic logic [ADDRESS_WIDTH-1:0] pc_inc(input logic [ADDRESS_WIDTH-1:0] pc);
    return pc + ADDRESS_WIDTH'(4);
  endfunction

  assign imem.imem_req_valid = rst_n && (state_q == ST_REQ);
  assign imem.imem_addr      = pc_q;
  assign req_hs              = imem.imem_req_valid && imem.imem_req_ready;
  assign resp_take           = (state_q == ST_WAIT) && imem.imem_resp_valid && !discard_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      skid_data_q   <= NOP_INSTR;
      skid_vld_q    <= 1'b0;
      discard_q     <= 1'b0;
      pc_f          <= RESET_PC;
      pc_plus4_f    <= pc_inc(RESET_PC);
      instr_f       <= NOP_INSTR;
      instr_valid_f <= 1'b0;
    end else if (pc_src_e) begin
      // Redirect wins over stall: flush output and skid, and make sure any
      // response already requested from the old path is thrown away.
      pc_q          <= pc_target_e;
      skid_vld_q    <= 1'b0;
      instr_f       <= NOP_INSTR;
      instr_valid_f <= 1'b0;
      case (state_q)
        ST_REQ: begin
          if (req_hs) begin
            req_pc_q  <= pc_q;
            state_q   <= ST_WAIT;
            discard_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem.imem_resp_valid) begin
            state_q   <= ST_REQ;
            discard_q <= 1'b0;
          end else begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_hs) begin
            req_pc_q <= pc_q;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.imem_resp_valid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= ST_REQ;
            end else begin
              pc_q <= pc_inc(req_pc_q);
              if (stall_f) begin
                skid_data_q <= imem.imem_resp_data;
                skid_vld_q  <= 1'b1;
                state_q     <= ST_HOLD;
              end else begin
                state_q <= ST_REQ;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!stall_f) begin
            skid_vld_q <= 1'b0;
            state_q    <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase

      // Output register only moves when decode is able to take it.
      if (!stall_f) begin
        if (resp_take) begin
          pc_f          <= req_pc_q;
          pc_plus4_f    <= pc_inc(req_pc_q);
          instr_f       <= imem.imem_resp_data;
          instr_valid_f <= 1'b1;
        end else if (state_q == ST_HOLD && skid_vld_q) begin
          pc_f          <= req_pc_q;
          pc_plus4_f    <= pc_inc(req_pc_q);
          instr_f       <= skid_data_q;
          instr_valid_f <= 1'b1;
        end else begin
          instr_f       <= NOP_INSTR;
          instr_valid_f <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all checked
// against a stream-level model of what decode should receive.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] instr_f;
  logic        instr_valid_f;

  fetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) imem_bus ();

  fetch_unit #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .RESET_PC     (32'h0000_0000),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (imem_bus),
    .stall_f      (stall_f),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .pc_f         (pc_f),
    .pc_plus4_f   (pc_plus4_f),
    .instr_f      (instr_f),
    .instr_valid_f(instr_valid_f)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          consumed = 0;
  logic [31:0] exp_pc;
  logic        pending = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: snapshot pre-edge state, advance, run memory responder and stream model.
  task automatic tick();
    logic        prst, pv, pst, prd, phs;
    logic [31:0] ppc, pp4, pins, ptgt, pa;
    prst = rst_n; pv = instr_valid_f; pst = stall_f; prd = pc_src_e; ptgt = pc_target_e;
    ppc = pc_f; pp4 = pc_plus4_f; pins = instr_f;
    phs = imem_bus.imem_req_valid && imem_bus.imem_req_ready;
    pa  = imem_bus.imem_addr;
    @(posedge clk);
    #1;
    imem_bus.imem_resp_valid = 1'b0;
    if (!prst) begin
      pending = 1'b0;
      exp_pc  = 32'h0;
    end else begin
      if (phs) begin
        check("one_outstanding", {31'b0, pending}, 32'h0);
        pending = 1'b1;
        cnt     = $urandom_range(lat_max, lat_min);
        paddr   = pa;
      end
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          imem_bus.imem_resp_valid = 1'b1;
          imem_bus.imem_resp_data  = mem(paddr);
          pending = 1'b0;
        end
      end
      if (prd) begin
        check("redir_valid", {31'b0, instr_valid_f}, 32'h0);
        check("redir_nop", instr_f, NOP);
        exp_pc = ptgt;
      end else if (pst) begin
        check("stall_hold_pc", pc_f, ppc);
        check("stall_hold_p4", pc_plus4_f, pp4);
        check("stall_hold_instr", instr_f, pins);
        check("stall_hold_valid", {31'b0, instr_valid_f}, {31'b0, pv});
      end else if (pv) begin
        check("cons_pc", ppc, exp_pc);
        check("cons_p4", pp4, exp_pc + 32'd4);
        check("cons_instr", pins, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
    if (!instr_valid_f) check("bubble_nop", instr_f, NOP);
  endtask

  task automatic run_until_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!instr_valid_f && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, {31'b0, instr_valid_f}, 32'h1);
  endtask

  task automatic run_until_req(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!imem_bus.imem_req_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, {31'b0, imem_bus.imem_req_valid}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    imem_bus.imem_req_ready = 1'b1;
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data = '0;
    exp_pc = '0;
    #2;

    // Reset state
    tick(); tick();
    check("rst_pc_f", pc_f, 32'h0);
    check("rst_p4", pc_plus4_f, 32'h4);
    check("rst_instr", instr_f, NOP);
    check("rst_valid", {31'b0, instr_valid_f}, 32'h0);
    check("rst_req_low", {31'b0, imem_bus.imem_req_valid}, 32'h0);

    // First fetch: request on cycle 0, instruction on decode 2 cycles later
    rst_n = 1'b1; #1;
    check("t1_req", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    check("t1_addr", imem_bus.imem_addr, 32'h0);
    tick();
    check("t1_wait_valid", {31'b0, instr_valid_f}, 32'h0);
    tick();
    check("t1_pc", pc_f, 32'h0);
    check("t1_p4", pc_plus4_f, 32'h4);
    check("t1_instr", instr_f, 32'h0050_0093);
    check("t1_valid", {31'b0, instr_valid_f}, 32'h1);

    // Streaming: one instruction every other cycle
    check("t2_addr4", imem_bus.imem_addr, 32'h4);
    tick();
    check("t2_gap", {31'b0, instr_valid_f}, 32'h0);
    tick();
    check("t2_pc4", pc_f, 32'h4);
    check("t2_valid4", {31'b0, instr_valid_f}, 32'h1);
    check("t2_addr8", imem_bus.imem_addr, 32'h8);

    // Decode stalls while the response for PC 8 lands
    tick();
    stall_f = 1'b1;
    tick();
    check("t3_hold_pc", pc_f, 32'h4);
    check("t3_no_req", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    tick();
    check("t3_no_req2", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    stall_f = 1'b0;
    tick();
    check("t3_pc8", pc_f, 32'h8);
    check("t3_valid8", {31'b0, instr_valid_f}, 32'h1);
    check("t3_addrC", imem_bus.imem_addr, 32'hC);

    // Redirect while waiting on PC 0x10
    tick(); tick();
    check("t4_pcC", pc_f, 32'hC);
    check("t4_addr10", imem_bus.imem_addr, 32'h10);
    lat_min = 3; lat_max = 3;
    tick();
    pc_src_e = 1'b1; pc_target_e = 32'h100;
    tick();
    pc_src_e = 1'b0; lat_min = 1; lat_max = 1;
    run_until_req("t4_req", 8);
    check("t4_addr100", imem_bus.imem_addr, 32'h100);
    run_until_valid("t4_out", 10);
    check("t4_pc100", pc_f, 32'h100);
    check("t4_instr100", instr_f, mem(32'h100));

    // Redirect and stall together: redirect wins
    stall_f = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    tick();
    check("t5_valid", {31'b0, instr_valid_f}, 32'h0);
    check("t5_nop", instr_f, NOP);
    stall_f = 1'b0; pc_src_e = 1'b0;

    // PC wrap at the top of the address space
    run_until_valid("t6_out", 12);
    check("t6_pc", pc_f, 32'hFFFF_FFFC);
    check("t6_p4", pc_plus4_f, 32'h0);
    run_until_req("t6_req", 8);
    check("t6_addr0", imem_bus.imem_addr, 32'h0);

    // Reset during an in-flight request
    lat_min = 3; lat_max = 3;
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_req", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    check("t6_rst_pc", pc_f, 32'h0);
    rst_n = 1'b1; #1;
    check("t6_rst_req_back", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    check("t6_rst_addr", imem_bus.imem_addr, 32'h0);
    imem_bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_resp", {31'b0, instr_valid_f}, 32'h0);
    end

    // Random traffic against the stream model
    lat_min = 1; lat_max = 3;
    consumed = 0;
    for (int i = 0; i < 2000; i++) begin
      imem_bus.imem_req_ready = ($urandom_range(9, 0) < 7);
      stall_f  = ($urandom_range(9, 0) < 3);
      pc_src_e = ($urandom_range(19, 0) == 0);
      pc_target_e = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    check("rand_progress", {31'b0, (consumed > 50)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
